cikis_paketleyici: RTL

Downstream stage of the task unit (gorev_birimi). It consumes the task unit's etkin/pixel output stream and packs 8-bit results 4-per-word, or 24-bit results 1-per-word, into 32-bit words. Packed words are queued in an internal word FIFO and presented to the bus/DMA writer on a valid/ready interface. It drives the task unit's stall input (stal_o) so that no result is ever lost under bus backpressure.

---
 rtl/cikis_paketleyici_pkg.sv | 19 +
 rtl/cikis_fifo.sv | 62 ++++++
 rtl/cikis_paketleyici.sv | 104 ++++++++++
 3 files changed

// File: rtl/cikis_paketleyici_pkg.sv
// Shared types and constants for the output packer and its word FIFO.
// A FIFO entry carries the packed word with its byte count and end-of-frame flag.
package cikis_paketleyici_pkg;

    typedef enum logic {
        CKS_MOD_8BIT  = 1'b0,
        CKS_MOD_24BIT = 1'b1
    } mod_t;

    localparam int CKS_KELIME_BIT = 32;
    localparam int CKS_GIRIS_BIT  = 36;

    typedef struct packed {
        logic                      son;
        logic [2:0]                bayt;
        logic [CKS_KELIME_BIT-1:0] veri;
    } giris_t;

endpackage

// File: rtl/cikis_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is read straight from storage.
// Clear has priority over push and pop; a pop while empty is ignored.
module cikis_fifo #(
    parameter int DERINLIK = 8,
    parameter int ADR_BIT  = 3,
    parameter int GENISLIK = 36
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                temizle,
    input  logic                yaz,
    input  logic                oku,
    input  logic [GENISLIK-1:0] giris,
    output logic [GENISLIK-1:0] cikis,
    output logic [ADR_BIT:0]    sayac,
    output logic [ADR_BIT:0]    sayac_sonraki,
    output logic                bos
);

    logic [GENISLIK-1:0] bellek [DERINLIK];
    logic [ADR_BIT-1:0]  yaz_ptr;
    logic [ADR_BIT-1:0]  oku_ptr;
    logic                oku_gercek;

    assign bos        = (sayac == '0);
    assign oku_gercek = oku && !bos;
    assign cikis      = bos ? '0 : bellek[oku_ptr];

    always_comb begin
        sayac_sonraki = sayac;
        if (temizle) begin
            sayac_sonraki = '0;
        end else if (yaz && !oku_gercek) begin
            sayac_sonraki = sayac + 1'b1;
        end else if (!yaz && oku_gercek) begin
            sayac_sonraki = sayac - 1'b1;
        end
    end

    // Pointer width equals log2(depth), so wrap-around is the natural overflow.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            sayac   <= '0;
        end else begin
            sayac <= sayac_sonraki;
            if (temizle) begin
                yaz_ptr <= '0;
                oku_ptr <= '0;
            end else begin
                if (yaz)        yaz_ptr <= yaz_ptr + 1'b1;
                if (oku_gercek) oku_ptr <= oku_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (yaz && !temizle) bellek[yaz_ptr] <= giris;
    end

endmodule

// File: rtl/cikis_paketleyici.sv
// Packs task-unit pixels into 32-bit words (4x8-bit or 1x24-bit) and queues them for the bus.
// The registered stall keeps one slot in reserve so an accepted pixel always has room.
module cikis_paketleyici
    import cikis_paketleyici_pkg::*;
#(
    parameter int DERINLIK = 8,
    parameter int ADR_BIT  = 3
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        basla_i,
    input  logic        mod_i,
    input  logic        etkin_i,
    input  logic [23:0] pixel_i,
    input  logic        son_i,
    output logic        stal_o,
    output logic        veri_gecerli_o,
    output logic [31:0] veri_o,
    output logic [2:0]  bayt_o,
    output logic        son_o,
    input  logic        veri_hazir_i
);

    mod_t              mod_r;
    logic [31:0]       paket;
    logic [1:0]        indeks;
    logic              kabul;
    logic              tamam;
    logic              yaz;
    giris_t            yeni;
    giris_t            bas;
    logic [ADR_BIT:0]  sayac;
    logic [ADR_BIT:0]  sayac_sonraki;
    logic              bos;

    always_comb begin
        kabul = etkin_i && !stal_o && !basla_i;
        tamam = (indeks == 2'd3) || son_i;
        yeni  = '0;
        yaz   = 1'b0;
        if (mod_r == CKS_MOD_24BIT) begin
            yeni.veri = {8'h00, pixel_i};
            yeni.bayt = 3'd3;
            yeni.son  = son_i;
            yaz       = kabul;
        end else begin
            // Lanes above the index are zero because the packer is cleared after every push.
            yeni.veri = paket | ({24'h0, pixel_i[7:0]} << {indeks, 3'b000});
            yeni.bayt = {1'b0, indeks} + 3'd1;
            yeni.son  = son_i;
            yaz       = kabul && tamam;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mod_r  <= CKS_MOD_8BIT;
            paket  <= '0;
            indeks <= '0;
            stal_o <= 1'b0;
        end else begin
            stal_o <= (sayac_sonraki >= (ADR_BIT+1)'(DERINLIK-1));
            if (basla_i) begin
                mod_r  <= mod_t'(mod_i);
                paket  <= '0;
                indeks <= '0;
            end else if (kabul && mod_r == CKS_MOD_8BIT) begin
                if (tamam) begin
                    paket  <= '0;
                    indeks <= '0;
                end else begin
                    paket  <= yeni.veri;
                    indeks <= indeks + 2'd1;
                end
            end
        end
    end

    cikis_fifo #(
        .DERINLIK (DERINLIK),
        .ADR_BIT  (ADR_BIT),
        .GENISLIK (CKS_GIRIS_BIT)
    ) u_fifo (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .temizle       (basla_i),
        .yaz           (yaz),
        .oku           (veri_hazir_i),
        .giris         (yeni),
        .cikis         (bas),
        .sayac         (sayac),
        .sayac_sonraki (sayac_sonraki),
        .bos           (bos)
    );

    assign veri_gecerli_o = !bos;
    assign veri_o         = bas.veri;
    assign bayt_o         = bas.bayt;
    assign son_o          = bas.son;

    a_dolu_yazma: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(yaz && sayac == (ADR_BIT+1)'(DERINLIK)));

endmodule
